// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-chain controller.
package shift_ctrl_pkg;

  localparam int unsigned SC_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  // Bit-index counter width; a single-stage chain still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Load handshake, serial chain drive/readback and completion status of shift_ctrl.
interface shift_ctrl_if
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SC_DEFAULT_WIDTH
);

  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic [WIDTH-1:0] DATA;
  logic             HOLD;
  logic [WIDTH-1:0] Q_PAR;
  logic             SER_ENB;
  logic             SER_IN;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [WIDTH-1:0] RD_DATA;

  modport slave (
    input  LOAD_VALID, DATA, HOLD, Q_PAR,
    output LOAD_READY, SER_ENB, SER_IN, BUSY, DONE, ERR, RD_DATA
  );

  modport master (
    output LOAD_VALID, DATA, HOLD, Q_PAR,
    input  LOAD_READY, SER_ENB, SER_IN, BUSY, DONE, ERR, RD_DATA
  );

endinterface

// File: rtl/shift_ctrl_cnt.sv
// Bit counter for the serialiser: synchronous clear, enable, saturates at WIDTH-1.
module shift_ctrl_cnt
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SC_DEFAULT_WIDTH,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o  = (cnt_q == CW'(WIDTH - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Serialises a word MSB-first into a chain of 1-bit cells and reads it back.
// Define SHIFT_CTRL_CHECK_EN to add the SETTLE cycle and live readback compare (ERR).
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SC_DEFAULT_WIDTH
) (
  input logic         CLK,
  input logic         CLR,
  shift_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic [CNT_W-1:0] bit_idx;

  logic ready;
  logic ser_enb;
  logic ser_in;
  logic busy;
  logic done;
  logic err;

  shift_ctrl_cnt #(
    .WIDTH (WIDTH),
    .CW    (CNT_W)
  ) u_cnt (
    .clk_i (CLK),
    .clr_i (CLR | cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  assign bit_idx = CNT_W'(WIDTH - 1) - cnt;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    rd_d     = rd_q;
    ready    = 1'b0;
    ser_enb  = 1'b0;
    ser_in   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (bus.LOAD_VALID) begin
          shadow_d = bus.DATA;
          cnt_clr  = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // SER_IN follows the counter, so it stays put for as long as HOLD freezes it.
        ser_in  = shadow_q[bit_idx];
        ser_enb = ~bus.HOLD;
        if (!bus.HOLD) begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
`ifdef SHIFT_CTRL_CHECK_EN
            state_d = SETTLE;
`else
            state_d = CHECK;
`endif
          end
        end
      end

      SETTLE: begin
        state_d = CHECK;
      end

      CHECK: begin
        done = 1'b1;
`ifdef SHIFT_CTRL_CHECK_EN
        err  = (bus.Q_PAR != shadow_q);
`else
        err  = 1'b0;
`endif
        rd_d    = bus.Q_PAR;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.LOAD_READY = ready;
  assign bus.SER_ENB    = ser_enb;
  assign bus.SER_IN     = ser_in;
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.ERR        = err;
  assign bus.RD_DATA    = rd_q;

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of cascaded 1-bit shift cells driven.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 CLR  in  1  reset, synchronous, active-high.
REQ-004 LOAD_VALID  in  1  requester presents a word on DATA.
REQ-005 LOAD_READY  out  1  controller accepts a word this cycle.
REQ-006 DATA  in  WIDTH  word to serialise into the chain.
REQ-007 HOLD  in  1  pause request; freezes shifting while high.
REQ-008 Q_PAR  in  WIDTH  parallel readback of chain; Q_PAR[0] = stage fed by SER_IN.
REQ-009 SER_ENB  out  1  drives ENB of every cell.
REQ-010 SER_IN  out  1  drives IN of stage 0.
REQ-011 BUSY  out  1  high in any state other than IDLE.
REQ-012 DONE  out  1  one-cycle completion pulse.
REQ-013 ERR  out  1  readback mismatch flag, valid while DONE=1.
REQ-014 RD_DATA  out  WIDTH  Q_PAR captured at completion.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, SETTLE, CHECK.
REQ-016 Accept = LOAD_VALID & LOAD_READY; LOAD_READY=1 only in IDLE; accept edge latches DATA into shadow, cnt=0, IDLE->SHIFT.
REQ-017 SHIFT: SER_ENB = ~HOLD; SER_IN = shadow[WIDTH-1-cnt] (MSB first); cnt increments on each edge with HOLD=0.
REQ-018 HOLD=1 in SHIFT: SER_ENB=0, cnt and SER_IN frozen, no timeout.
REQ-019 Edge with HOLD=0 and cnt=WIDTH-1: SHIFT->SETTLE; after WIDTH shifts Q_PAR SHALL equal shadow.
REQ-020 SETTLE: one cycle, SER_ENB=0, HOLD ignored; ->CHECK.
REQ-021 CHECK: one cycle, DONE=1, ERR=(Q_PAR!=shadow), RD_DATA<=Q_PAR on that edge; ->IDLE.
REQ-022 SER_ENB SHALL be 0 in IDLE, SETTLE, CHECK; SER_IN SHALL be 0 outside SHIFT.
REQ-023 Minimum accept-to-accept spacing without HOLD: WIDTH+3 cycles; LOAD_VALID outside IDLE ignored, not queued.
REQ-024 cnt width = clog2(WIDTH), minimum 1; no wrap beyond WIDTH-1.

Reset
REQ-025 CLR=1 at an edge: state=IDLE, cnt=0, shadow=0, RD_DATA=0; next cycle SER_ENB=0, SER_IN=0, DONE=0, ERR=0, BUSY=0, LOAD_READY=1.
REQ-026 CLR has priority over accept, HOLD and every state transition; mid-SHIFT CLR aborts with no DONE.
REQ-027 Controller SHALL NOT clear the chain cells; partial contents remain after abort.

Configuration
REQ-028 Macro SHIFT_CTRL_CHECK_EN defined: SETTLE and CHECK present as above, ERR live.
REQ-029 Macro undefined: SHIFT->CHECK directly (no SETTLE), ERR tied 0, RD_DATA still captured; spacing WIDTH+2.

Structure
REQ-030 Package shift_ctrl_pkg SHALL hold the state enum, default WIDTH and the cnt-width function.
REQ-031 One sub-module shift_ctrl_cnt: bit counter with enable, clear, terminal-count output.

Verification (WIDTH=4, behavioural 4-cell chain model on Q_PAR)
REQ-032 DATA=4'b1011 accepted -> SER_IN 1,0,1,1 with SER_ENB=1 for 4 cycles, SETTLE, DONE at cycle 6 after accept, ERR=0, RD_DATA=4'b1011.
REQ-033 HOLD=1 for 3 cycles after 2nd bit -> SER_ENB=0 those cycles, bit order unchanged, DONE 3 cycles later, ERR=0.
REQ-034 CLR after 2 shifted bits -> next cycle IDLE, LOAD_READY=1, SER_ENB=0, no DONE pulse.
REQ-035 Stage 2 stuck-at-0, DATA=4'b1111 -> DONE with ERR=1, RD_DATA=4'b1011.
REQ-036 LOAD_VALID held high continuously -> accepts exactly every 7 cycles; DATA changes while BUSY have no effect.
REQ-037 Build without SHIFT_CTRL_CHECK_EN, DATA=4'b0110 -> DONE at cycle 5 after accept, ERR=0, RD_DATA=4'b0110.
